piece_drop_ctrl: RTL and testbench

//  Gravity stage for the 16x16 Connect Four board. Accepts a column drop request and

---
 rtl/piece_drop_ctrl.sv | 119 +++++++++++
 tb/tb_piece_drop_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_drop_ctrl.sv
// rtl/piece_drop_ctrl.sv - gravity stage: drops a piece down a column one row per tick, then writes the landing cell
// Optional abort input enabled by defining PIECE_DROP_ABORT_EN.
module piece_drop_ctrl #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             tick,
    input  logic             drop_req,
    input  logic [COL_W-1:0] drop_col,
    input  logic             player,
`ifdef PIECE_DROP_ABORT_EN
    input  logic             abort,
`endif
    output logic [COL_W-1:0] rd_col,
    input  logic [ROWS-1:0]  rd_occ,
    output logic             timer_restart,
    output logic             busy,
    output logic             reject,
    output logic             fall_valid,
    output logic [ROW_W-1:0] fall_row,
    output logic [COL_W-1:0] fall_col,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic             wr_player,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;

    state_t           state;
    logic             fall_player;
    logic [ROW_W-1:0] next_row;
    logic             at_bottom;
    logic             blocked;
    logic             abort_hit;

    // The occupancy port follows the requested column until a piece is accepted.
    assign rd_col    = (state == IDLE) ? drop_col : fall_col;
    assign next_row  = fall_row + 1'b1;
    assign at_bottom = (fall_row == ROW_W'(ROWS - 1));
    assign blocked   = rd_occ[next_row];

`ifdef PIECE_DROP_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            fall_player   <= 1'b0;
            timer_restart <= 1'b0;
            busy          <= 1'b0;
            reject        <= 1'b0;
            fall_valid    <= 1'b0;
            fall_row      <= '0;
            fall_col      <= '0;
            wr_en         <= 1'b0;
            wr_row        <= '0;
            wr_col        <= '0;
            wr_player     <= 1'b0;
            done          <= 1'b0;
        end else begin
            timer_restart <= 1'b0;
            reject        <= 1'b0;
            wr_en         <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop_req) begin
                        if (rd_occ[0]) begin
                            reject <= 1'b1;
                        end else begin
                            state         <= FALL;
                            fall_row      <= '0;
                            fall_col      <= drop_col;
                            fall_player   <= player;
                            busy          <= 1'b1;
                            fall_valid    <= 1'b1;
                            timer_restart <= 1'b1;
                        end
                    end
                end
                FALL: begin
                    // Abort wins over a tick arriving in the same cycle.
                    if (abort_hit) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        fall_valid <= 1'b0;
                    end else if (tick) begin
                        if (at_bottom || blocked) begin
                            state      <= LAND;
                            fall_valid <= 1'b0;
                            wr_en      <= 1'b1;
                            done       <= 1'b1;
                            wr_row     <= fall_row;
                            wr_col     <= fall_col;
                            wr_player  <= fall_player;
                        end else begin
                            fall_row <= next_row;
                        end
                    end
                end
                LAND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb/tb_piece_drop_ctrl.sv - scoreboard bench for piece_drop_ctrl against a board-level landing model
module tb_piece_drop_ctrl;

    localparam int ROWS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        drop_req;
    logic [3:0]  drop_col;
    logic        player;
    logic        abort;
    logic [3:0]  rd_col;
    logic [15:0] rd_occ;
    logic        timer_restart, busy, reject, fall_valid;
    logic [3:0]  fall_row, fall_col;
    logic        wr_en;
    logic [3:0]  wr_row, wr_col;
    logic        wr_player, done;

    typedef struct {
        bit is_rej;
        int row;
        int col;
        bit pl;
        int ticks;
    } exp_t;

    exp_t        q[$];
    logic [15:0] board[16];
    int          counted;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rd_occ = board[rd_col];

    piece_drop_ctrl dut (
        .clk(clk), .RST(rst_n), .tick(tick), .drop_req(drop_req),
        .drop_col(drop_col), .player(player),
`ifdef PIECE_DROP_ABORT_EN
        .abort(abort),
`endif
        .rd_col(rd_col), .rd_occ(rd_occ), .timer_restart(timer_restart),
        .busy(busy), .reject(reject), .fall_valid(fall_valid),
        .fall_row(fall_row), .fall_col(fall_col), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Landing row: one above the first occupied cell below the top, else the bottom row.
    function automatic int land_row(input int col);
        for (int i = 1; i < ROWS; i++)
            if (board[col][i]) return i - 1;
        return ROWS - 1;
    endfunction

    function automatic logic [31:0] all_outs();
        return {9'd0, wr_en, done, busy, reject, fall_valid, timer_restart, wr_player,
                fall_row, fall_col, wr_row, wr_col};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wr_en || done) chk("done_with_wr_en", done, wr_en);
            if (wr_en) begin
                chk("fall_valid_in_land", fall_valid, 0);
                if (q.size() == 0 || q[0].is_rej) begin
                    chk("unexpected_wr_en", wr_en, 0);
                end else begin
                    e = q.pop_front();
                    chk("wr_row", wr_row, e.row);
                    chk("wr_col", wr_col, e.col);
                    chk("wr_player", wr_player, e.pl);
                    chk("ticks_before_write", counted, e.ticks);
                    board[e.col][e.row] = 1'b1;
                end
            end
            if (reject) begin
                if (q.size() == 0 || !q[0].is_rej) begin
                    chk("unexpected_reject", reject, 0);
                end else begin
                    e = q.pop_front();
                    chk("reject_busy", busy, 0);
                end
            end
        end
    end

    task automatic do_drop(input int col, input bit pl, input int rst_at, input int abort_at);
        int  needed;
        bit  full;
        int  cyc;
        exp_t e;
        needed = land_row(col);
        needed = needed + 1;
        full   = board[col][0];
        @(negedge clk);
        drop_req = 1'b1;
        drop_col = 4'(col);
        player   = pl;
        tick     = 1'($urandom % 2);
        counted  = 0;
        if (full) begin
            e = '{is_rej: 1'b1, row: 0, col: col, pl: pl, ticks: 0};
            q.push_back(e);
        end else if (rst_at < 0 && abort_at < 0) begin
            e = '{is_rej: 1'b0, row: needed - 1, col: col, pl: pl, ticks: needed};
            q.push_back(e);
        end
        @(negedge clk);
        drop_req = 1'b0;
        tick     = 1'b0;
        if (full) begin
            chk("reject_no_busy", busy, 0);
            chk("reject_no_fall", fall_valid, 0);
            repeat (2) @(negedge clk);
            chk("reject_cleared", reject, 0);
            chk("reject_scoreboard_empty", q.size(), 0);
            return;
        end
        chk("accept_timer_restart", timer_restart, 1);
        chk("accept_busy", busy, 1);
        chk("accept_fall_col", fall_col, col);
        cyc = 0;
        while (counted < needed && cyc < 400) begin
            chk("fall_row", fall_row, counted);
            chk("fall_valid", fall_valid, 1);
            chk("rd_col_latched", rd_col, col);
            if (cyc > 0) chk("timer_restart_once", timer_restart, 0);
            if (rst_at == counted) begin
                tick = 1'b0;
                drop_req = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("reset_mid_fall_outputs", all_outs(), 0);
                repeat (3) @(negedge clk);
                chk("reset_held_outputs", all_outs(), 0);
                rst_n = 1'b1;
                return;
            end
            if (abort_at == counted) begin
                abort = 1'b1;
                tick  = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                tick  = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_fall_valid", fall_valid, 0);
                chk("abort_row_held", fall_row, abort_at);
                repeat (3) @(negedge clk);
                chk("abort_no_write", wr_en, 0);
                return;
            end
            drop_req = ($urandom % 4 == 0);
            drop_col = 4'($urandom);
            tick = 1'($urandom % 2);
            if (tick) counted++;
            cyc++;
            @(negedge clk);
        end
        drop_req = 1'b0;
        if (counted < needed) chk("fall_timeout", counted, needed);
        for (int k = 0; k < 6 && busy; k++) begin
            tick = 1'($urandom % 2);
            @(negedge clk);
        end
        tick = 1'b0;
        chk("busy_released", busy, 0);
        chk("write_pending", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        drop_req = 1'b0;
        drop_col = '0;
        player = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 16; c++) begin
            int h;
            h = $urandom_range(0, 16);
            board[c] = (h == 0) ? 16'h0 : (16'hFFFF << (16 - h));
        end
        board[0] = 16'hFFFF;
        board[1] = 16'h0;
        board[2] = 16'h0;
        board[3] = 16'hFC00;
        board[5] = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_state", all_outs(), 0);
        chk("reset_rd_col_follows_req", rd_col, 0);
        rst_n = 1'b1;

        do_drop(5, 1'b1, -1, -1);
        do_drop(3, 1'b0, -1, -1);
        do_drop(0, 1'b1, -1, -1);
        do_drop(2, 1'b0, 6, -1);
        do_drop(2, 1'b1, -1, -1);
        do_drop(1, 1'b1, -1, -1);
        repeat (4) begin
            @(negedge clk);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
        chk("idle_ticks_row", fall_row, 15);
        chk("idle_ticks_busy", busy, 0);
`ifdef PIECE_DROP_ABORT_EN
        do_drop(1, 1'b0, -1, 4);
        do_drop(1, 1'b0, -1, -1);
`endif
        repeat (40) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                tick = 1'($urandom % 2);
            end
            tick = 1'b0;
            do_drop($urandom_range(0, 15), 1'($urandom % 2), -1, -1);
        end
        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
